// File: rtl/ft245_emulator_pkg.sv
// Shared definitions for the FT245 device-side emulator: FSM encodings,
// default pin timing in ns, and the ns-to-cycle conversion.
package ft245_emulator_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_DELAY = 2'd1;
    localparam logic [1:0] R_HOLD  = 2'd2;
    localparam logic [1:0] R_PRE   = 2'd3;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_HOLD  = 2'd1;
    localparam logic [1:0] T_PRE   = 2'd2;

    localparam real DEF_CLOCK_PERIOD_NS = 10.0;
    localparam real DEF_RD_DELAY_NS     = 20.0;
    localparam real DEF_RXF_INACTIVE_NS = 25.0;
    localparam real DEF_TXE_INACTIVE_NS = 25.0;

    // ceil(ns / period), never less than one cycle
    function automatic int ns_to_cycles(input real ns, input real period);
        int n;
        n = $rtoi(ns / period);
        if (real'(n) * period < ns) n = n + 1;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/ft245_emulator_if.sv
// FT245 pin bundle. master = FPGA/host-interface side, slave = emulated chip.
interface ft245_emulator_if;
    logic [7:0] rx_data_245;
    logic       rxf_245;
    logic       rx_245;
    logic [7:0] tx_data_245;
    logic       txe_245;
    logic       wr_245;
    logic       tx_oe_245;

    modport master (
        input  rx_data_245, rxf_245, txe_245,
        output rx_245, tx_data_245, wr_245, tx_oe_245
    );

    modport slave (
        output rx_data_245, rxf_245, txe_245,
        input  rx_245, tx_data_245, wr_245, tx_oe_245
    );
endinterface

// File: rtl/ft245_emulator_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head; head reads as 0x00 when empty.
module ft245_emulator_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_wr;
    logic          do_rd;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign do_wr     = wr_en_i & ~full_o;
    assign do_rd     = rd_en_i & ~empty_o;
    assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd)
            count_d = count_q + (AW+1)'(1);
        else if (do_rd && !do_wr)
            count_d = count_q - (AW+1)'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/ft245_emulator.sv
// Device-side FT245 model: RX/TX FIFOs between stream ports and FT245 pins.
// Define FT245_EMU_SYNC_EN to add 2-flop synchronizers on the host-driven pins.
module ft245_emulator
    import ft245_emulator_pkg::*;
#(
    parameter real CLOCK_PERIOD_NS = DEF_CLOCK_PERIOD_NS,
    parameter int  RX_DEPTH        = 16,
    parameter int  TX_DEPTH        = 16,
    parameter real RD_DELAY_NS     = DEF_RD_DELAY_NS,
    parameter real RXF_INACTIVE_NS = DEF_RXF_INACTIVE_NS,
    parameter real TXE_INACTIVE_NS = DEF_TXE_INACTIVE_NS
) (
    input  logic              clk,
    input  logic              rst,
    ft245_emulator_if.slave   pins,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              protocol_err
);
    localparam logic [7:0] RD_CNT  = 8'(ns_to_cycles(RD_DELAY_NS, CLOCK_PERIOD_NS));
    localparam logic [7:0] RXF_CNT = 8'(ns_to_cycles(RXF_INACTIVE_NS, CLOCK_PERIOD_NS));
    localparam logic [7:0] TXE_CNT = 8'(ns_to_cycles(TXE_INACTIVE_NS, CLOCK_PERIOD_NS));

    logic  rd_pin, wr_pin, oe_pin;
    byte_t txd_pin;

`ifdef FT245_EMU_SYNC_EN
    logic [1:0] rd_sync_q, wr_sync_q, oe_sync_q;
    byte_t      txd_sync0_q, txd_sync1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sync_q   <= 2'b11;
            wr_sync_q   <= 2'b11;
            oe_sync_q   <= 2'b00;
            txd_sync0_q <= 8'h00;
            txd_sync1_q <= 8'h00;
        end else begin
            rd_sync_q   <= {rd_sync_q[0], pins.rx_245};
            wr_sync_q   <= {wr_sync_q[0], pins.wr_245};
            oe_sync_q   <= {oe_sync_q[0], pins.tx_oe_245};
            txd_sync0_q <= pins.tx_data_245;
            txd_sync1_q <= txd_sync0_q;
        end
    end

    assign rd_pin  = rd_sync_q[1];
    assign wr_pin  = wr_sync_q[1];
    assign oe_pin  = oe_sync_q[1];
    assign txd_pin = txd_sync1_q;
`else
    assign rd_pin  = pins.rx_245;
    assign wr_pin  = pins.wr_245;
    assign oe_pin  = pins.tx_oe_245;
    assign txd_pin = pins.tx_data_245;
`endif

    logic  rd_cur_q, rd_prev_q, wr_cur_q, wr_prev_q, oe_q;
    byte_t txd_q;

    // Data and OE are registered alongside WR# so the push sees them aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cur_q  <= 1'b1;
            rd_prev_q <= 1'b1;
            wr_cur_q  <= 1'b1;
            wr_prev_q <= 1'b1;
            oe_q      <= 1'b0;
            txd_q     <= 8'h00;
        end else begin
            rd_cur_q  <= rd_pin;
            rd_prev_q <= rd_cur_q;
            wr_cur_q  <= wr_pin;
            wr_prev_q <= wr_cur_q;
            oe_q      <= oe_pin;
            txd_q     <= txd_pin;
        end
    end

    logic rd_fall, rd_rise, wr_fall, wr_rise;
    assign rd_fall = rd_prev_q & ~rd_cur_q;
    assign rd_rise = ~rd_prev_q & rd_cur_q;
    assign wr_fall = wr_prev_q & ~wr_cur_q;
    assign wr_rise = ~wr_prev_q & wr_cur_q;

    logic  rx_full, rx_empty, rx_pop, tx_full, tx_empty, tx_push;
    byte_t rx_head;

    assign in_ready  = ~rst & ~rx_full;
    assign out_valid = ~tx_empty;

    ft245_emulator_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .wr_en_i(in_valid & in_ready), .wr_data_i(in_data),
        .rd_en_i(rx_pop), .rd_data_o(rx_head),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    ft245_emulator_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .wr_en_i(tx_push), .wr_data_i(txd_q),
        .rd_en_i(out_valid & out_ready), .rd_data_o(out_data),
        .full_o(tx_full), .empty_o(tx_empty)
    );

    logic [1:0] rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [7:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic       rxf_q, rxf_d, txe_q, txe_d, rx_err, tx_err, err_q;
    byte_t      rx_dout_q, rx_dout_d;

    // rx_cnt counts edges since RD# was sampled low, so the fall edge itself is 1.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rxf_d      = rxf_q;
        rx_dout_d  = rx_dout_q;
        rx_pop     = 1'b0;
        rx_err     = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rxf_d = rx_empty;
                if (rd_fall && !rxf_q) begin
                    if (RD_CNT == 8'd1) begin
                        rx_dout_d  = rx_head;
                        rx_state_d = R_HOLD;
                    end else begin
                        rx_cnt_d   = 8'd1;
                        rx_state_d = R_DELAY;
                    end
                end else if (rd_fall) begin
                    rx_err = 1'b1;
                end
            end
            R_DELAY: begin
                if (rd_rise) begin
                    rx_pop     = 1'b1;
                    rx_err     = 1'b1;
                    rxf_d      = 1'b1;
                    rx_cnt_d   = 8'd1;
                    rx_state_d = R_PRE;
                end else if (rx_cnt_q == RD_CNT - 8'd1) begin
                    rx_dout_d  = rx_head;
                    rx_state_d = R_HOLD;
                end else begin
                    rx_cnt_d = rx_cnt_q + 8'd1;
                end
            end
            R_HOLD: begin
                if (rd_rise) begin
                    rx_pop     = 1'b1;
                    rxf_d      = 1'b1;
                    rx_dout_d  = 8'h00;
                    rx_cnt_d   = 8'd1;
                    rx_state_d = R_PRE;
                end
            end
            R_PRE: begin
                if (rx_cnt_q == RXF_CNT) begin
                    rxf_d      = rx_empty;
                    rx_state_d = R_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 8'd1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        txe_d      = txe_q;
        tx_push    = 1'b0;
        tx_err     = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                txe_d = tx_full;
                if (wr_fall) begin
                    txe_d      = 1'b1;
                    tx_state_d = T_HOLD;
                    if (!txe_q && oe_q) tx_push = 1'b1;
                    else                tx_err  = 1'b1;
                end
            end
            T_HOLD: begin
                if (wr_rise) begin
                    tx_cnt_d   = 8'd1;
                    tx_state_d = T_PRE;
                end
            end
            T_PRE: begin
                if (tx_cnt_q == TXE_CNT) begin
                    txe_d      = tx_full;
                    tx_state_d = T_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 8'd1;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= 8'd0;
            rxf_q      <= 1'b1;
            rx_dout_q  <= 8'h00;
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= 8'd0;
            txe_q      <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rxf_q      <= rxf_d;
            rx_dout_q  <= rx_dout_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            txe_q      <= txe_d;
            err_q      <= err_q | rx_err | tx_err;
        end
    end

    assign pins.rx_data_245 = rx_dout_q;
    assign pins.rxf_245     = rxf_q;
    assign pins.txe_245     = txe_q;
    assign protocol_err     = err_q;

endmodule
